tmds_rx_decoder: RTL and testbench
==================================

Name: tmds_rx_decoder

Overview:
- Receive-side counterpart of the HDMI/DVI TMDS transmit path. Runs on the pixel clock.
- Input: unaligned 10-bit raw words, one per cycle, from a 1:10 deserializer on the same channel.
- Word alignment: finds the 10-bit boundary using TMDS control tokens, with a bit-slip search FSM.
- Output: decoded 8-bit pixel data or 2-bit control value, plus lock status. One instance per TMDS channel.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens needed at the current offset to declare lock.
- SEARCH_TIMEOUT, 64: words spent at one offset in SEARCH before slipping to the next.
- TOKEN_TIMEOUT, 4096: words allowed in LOCKED without any token before lock is dropped.

Ports:
- clk_pixel_in, input, 1: pixel clock; the only clock.
- rst_in, input, 1: synchronous, active-high reset.
- tmds_raw_in, input, 10: raw deserialized word; bit 0 is the earliest received bit.
- data_out, output, 8: decoded pixel byte.
- ctrl_out, output, 2: {c1,c0} of the most recent control token.
- de_out, output, 1: data enable; high when data_out holds a decoded data word.
- locked_out, output, 1: word alignment achieved.
- offset_out, output, 4: current alignment offset, 0..9.

Behaviour:
- Clock and reset: one clock, clk_pixel_in. rst_in is synchronous and active-high.
- Reset values: data_out=0, ctrl_out=0, de_out=0, locked_out=0, offset_out=0, FSM=SEARCH, all counters=0, hist=0.
- History register: each edge, hist[19:0] <= {tmds_raw_in, hist[19:10]}. Bit 0 is the oldest bit.
- Aligned word: w = hist[offset+9 : offset]. w[0] is the earliest bit of the symbol.
  - If the transmitted stream has symbols starting at stream bit index p mod 10, relative to raw-word bit 0, then the correct offset is p.
- Latency: a raw word sampled at edge E completes the aligned word evaluated during cycle E+1. The decoded outputs for that word are registered at edge E+2. There are no bubbles; one word per cycle.
- Token match (w as bits 9..0):
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
- Data decode, for non-token w:
  - d = w[9] ? ~w[7:0] : w[7:0].
  - data[0] = d[0].
  - For i = 1..7: data[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM state SEARCH:
  - Each evaluated word increments search_cnt.
  - A token increments match_cnt; a non-token clears match_cnt.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED, set locked_out=1 at the same edge that word's outputs are registered, clear counters.
  - Otherwise, when search_cnt reaches SEARCH_TIMEOUT: slip. offset <= (offset==9) ? 0 : offset+1; clear both counters. The next evaluated word uses the new offset.
  - If lock and timeout occur on the same word, lock wins and there is no slip.
  - Outputs in SEARCH: de_out=0, data_out=0, ctrl_out=0.
- FSM state LOCKED:
  - offset is frozen.
  - Token word: ctrl_out <= value, de_out <= 0, data_out <= 0, token_timer cleared.
  - Non-token word: de_out <= 1, data_out <= decoded byte, ctrl_out holds, token_timer increments.
  - When token_timer reaches TOKEN_TIMEOUT: go to SEARCH, locked_out <= 0, outputs cleared, offset <= offset+1 (mod 10), counters cleared.
- Reset mid-operation: rst_in overrides everything on that edge and returns all state to the reset values. Lock is re-acquired from offset 0.
- Counter widths: sized by $clog2 of (parameter+1). No wrap-around before the thresholds.
- offset_out always reflects the offset used for the word currently registered on the outputs.

Test Plan:
- Aligned lock: reset, then a continuous token stream 1101010100 at p=0. Required: locked_out=1 exactly LOCK_COUNT+2 cycles after the first word; offset_out=0; ctrl_out=00; de_out=0.
- Bit slip: the same token stream delayed by 3 bits. Required: offset steps 0→1→2→3, each of offsets 0..2 lasting SEARCH_TIMEOUT words. Lock after 3*64+8 words; offset_out=3.
- Data decode: after lock at p=7, send 8-bit data 0x00, 0xFF, 0xA5 encoded by the team's TMDS encoder, interleaved with 2 tokens of ctrl 11. Required: de_out pulses with data_out=0x00, 0xFF, 0xA5 in order, 2 cycles after each word. ctrl_out=11 held across the data.
- Token mapping: locked, send the four tokens in sequence. Required: ctrl_out = 00, 01, 10, 11 on consecutive cycles, with de_out=0 throughout.
- Loss of lock: locked, then 4096 consecutive non-token data words. Required: locked_out falls on the 4096th; offset_out increments by 1; de_out=0 and data_out=0 from then on.
- Reset mid-lock: assert rst_in for 1 cycle while locked at offset 5. Required: next edge gives locked_out=0, offset_out=0, all outputs 0. Re-lock to offset 5 after 5*64+8 words of tokens.

Source files
------------

// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: finds the 10-bit symbol boundary from control tokens
// and decodes aligned words into pixel bytes or control values.
module tmds_rx_decoder #(
   parameter int LOCK_COUNT     = 8,
   parameter int SEARCH_TIMEOUT = 64,
   parameter int TOKEN_TIMEOUT  = 4096
) (
   input  logic       clk_pixel_in,
   input  logic       rst_in,
   input  logic [9:0] tmds_raw_in,
   output logic [7:0] data_out,
   output logic [1:0] ctrl_out,
   output logic       de_out,
   output logic       locked_out,
   output logic [3:0] offset_out
);

   localparam int MC_W = $clog2(LOCK_COUNT + 1);
   localparam int SC_W = $clog2(SEARCH_TIMEOUT + 1);
   localparam int TT_W = $clog2(TOKEN_TIMEOUT + 1);

   localparam logic [MC_W-1:0] MATCH_LAST  = MC_W'(LOCK_COUNT - 1);
   localparam logic [SC_W-1:0] SEARCH_LAST = SC_W'(SEARCH_TIMEOUT - 1);
   localparam logic [TT_W-1:0] TOKEN_LAST  = TT_W'(TOKEN_TIMEOUT - 1);

   typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [19:0]      hist_q, hist_d;
   logic [3:0]       offset_q, offset_d;
   logic [3:0]       offset_out_q, offset_out_d;
   logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
   logic [SC_W-1:0]  search_cnt_q, search_cnt_d;
   logic [TT_W-1:0]  token_timer_q, token_timer_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             de_q, de_d;
   logic             locked_q, locked_d;

   logic [9:0]       cand [16];
   logic [9:0]       word;
   logic             is_token;
   logic [1:0]       tok_ctrl;
   logic [7:0]       d_pre;
   logic [7:0]       dec;
   logic [3:0]       offset_inc;

   // One candidate symbol per bit offset; offsets 10..15 are unreachable.
   for (genvar gi = 0; gi < 16; gi++) begin : g_cand
      if (gi < 10) begin : g_valid
         assign cand[gi] = hist_q[gi+9:gi];
      end else begin : g_pad
         assign cand[gi] = '0;
      end
   end

   assign word       = cand[offset_q];
   assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
   assign hist_d     = {tmds_raw_in, hist_q[19:10]};
   assign d_pre      = word[9] ? ~word[7:0] : word[7:0];
   assign dec[0]     = d_pre[0];

   for (genvar gi = 1; gi < 8; gi++) begin : g_dec
      assign dec[gi] = word[8] ? (d_pre[gi] ^ d_pre[gi-1]) : ~(d_pre[gi] ^ d_pre[gi-1]);
   end

   always_comb begin
      is_token = 1'b1;
      tok_ctrl = 2'b00;
      case (word)
         10'b1101010100: tok_ctrl = 2'b00;
         10'b0010101011: tok_ctrl = 2'b01;
         10'b0101010100: tok_ctrl = 2'b10;
         10'b1010101011: tok_ctrl = 2'b11;
         default:        is_token = 1'b0;
      endcase
   end

   // Next-state: alignment search, lock tracking and counters.
   always_comb begin
      state_d       = state_q;
      offset_d      = offset_q;
      match_cnt_d   = match_cnt_q;
      search_cnt_d  = search_cnt_q;
      token_timer_d = token_timer_q;
      case (state_q)
         ST_SEARCH: begin
            search_cnt_d = search_cnt_q + SC_W'(1);
            match_cnt_d  = is_token ? match_cnt_q + MC_W'(1) : '0;
            if (is_token && (match_cnt_q == MATCH_LAST)) begin
               state_d       = ST_LOCKED;
               match_cnt_d   = '0;
               search_cnt_d  = '0;
               token_timer_d = '0;
            end else if (search_cnt_q == SEARCH_LAST) begin
               offset_d     = offset_inc;
               match_cnt_d  = '0;
               search_cnt_d = '0;
            end
         end
         ST_LOCKED: begin
            if (is_token) begin
               token_timer_d = '0;
            end else if (token_timer_q == TOKEN_LAST) begin
               state_d       = ST_SEARCH;
               offset_d      = offset_inc;
               token_timer_d = '0;
               match_cnt_d   = '0;
               search_cnt_d  = '0;
            end else begin
               token_timer_d = token_timer_q + TT_W'(1);
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // Outputs only carry symbols evaluated while locked and staying locked.
   always_comb begin
      data_d       = '0;
      ctrl_d       = '0;
      de_d         = 1'b0;
      locked_d     = (state_d == ST_LOCKED);
      offset_out_d = offset_q;
      if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
         if (is_token) begin
            ctrl_d = tok_ctrl;
         end else begin
            ctrl_d = ctrl_q;
            de_d   = 1'b1;
            data_d = dec;
         end
      end
   end

   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         state_q       <= ST_SEARCH;
         hist_q        <= '0;
         offset_q      <= '0;
         offset_out_q  <= '0;
         match_cnt_q   <= '0;
         search_cnt_q  <= '0;
         token_timer_q <= '0;
         data_q        <= '0;
         ctrl_q        <= '0;
         de_q          <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         hist_q        <= hist_d;
         offset_q      <= offset_d;
         offset_out_q  <= offset_out_d;
         match_cnt_q   <= match_cnt_d;
         search_cnt_q  <= search_cnt_d;
         token_timer_q <= token_timer_d;
         data_q        <= data_d;
         ctrl_q        <= ctrl_d;
         de_q          <= de_d;
         locked_q      <= locked_d;
      end
   end

   assign data_out   = data_q;
   assign ctrl_out   = ctrl_q;
   assign de_out     = de_q;
   assign locked_out = locked_q;
   assign offset_out = offset_out_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: bit-level transmitter with adjustable phase,
// a word-level reference model, directed lock/decode sequences and random traffic.
module tb_tmds_rx_decoder;

   localparam int LOCK_COUNT     = 8;
   localparam int SEARCH_TIMEOUT = 64;
   localparam int TOKEN_TIMEOUT  = 4096;

   logic       clk_pixel_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [9:0] tmds_raw_in = '0;
   logic [7:0] data_out;
   logic [1:0] ctrl_out;
   logic       de_out;
   logic       locked_out;
   logic [3:0] offset_out;

   tmds_rx_decoder #(
      .LOCK_COUNT(LOCK_COUNT),
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
   ) dut (
      .clk_pixel_in(clk_pixel_in),
      .rst_in(rst_in),
      .tmds_raw_in(tmds_raw_in),
      .data_out(data_out),
      .ctrl_out(ctrl_out),
      .de_out(de_out),
      .locked_out(locked_out),
      .offset_out(offset_out)
   );

   always #5 clk_pixel_in = ~clk_pixel_in;

   int checks = 0;
   int errors = 0;

   logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   // Reference model state: the last two raw words and plain integer counters.
   int         m_h0, m_h1, m_off, m_offout, m_words, m_run, m_quiet;
   bit         m_locked, m_de;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;

   bit         tx_bits [$];
   int         enc_cnt = 0;
   int         off_hist [2001];

   typedef struct {
      logic [9:0] sym;
      logic       exp_de;
      logic [7:0] exp_data;
      logic [1:0] exp_ctrl;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int tok_index(input int w);
      for (int c = 0; c < 4; c++)
         if (w == int'(tok_tab[c])) return c;
      return -1;
   endfunction

   function automatic logic [7:0] ref_decode(input int w);
      int d, x;
      d = ((w & 512) != 0) ? (~w & 255) : (w & 255);
      x = d ^ ((d << 1) & 255);
      if ((w & 256) == 0) x = x ^ 'hFE;
      return x[7:0];
   endfunction

   function automatic logic [9:0] tmds_encode(input logic [7:0] din);
      logic [8:0] qm;
      logic [9:0] q;
      int n1, n1q, n0q;
      n1 = $countones(din);
      qm[0] = din[0];
      if (n1 > 4 || (n1 == 4 && din[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ din[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (enc_cnt == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt += 2 * int'(qm[8]) + (n0q - n1q);
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         enc_cnt += -2 * int'(!qm[8]) + (n1q - n0q);
      end
      return q;
   endfunction

   task automatic model_reset();
      m_h0 = 0; m_h1 = 0; m_off = 0; m_offout = 0;
      m_words = 0; m_run = 0; m_quiet = 0;
      m_locked = 0; m_de = 0; m_data = '0; m_ctrl = '0;
   endtask

   task automatic model_step(input int raw);
      int w, tc;
      w = (((m_h1 << 10) | m_h0) >> m_off) & 1023;
      m_h0 = m_h1;
      m_h1 = raw;
      m_offout = m_off;
      tc = tok_index(w);
      if (!m_locked) begin
         m_de = 0; m_data = '0; m_ctrl = '0;
         m_words++;
         m_run = (tc >= 0) ? m_run + 1 : 0;
         if (m_run == LOCK_COUNT) begin
            m_locked = 1; m_words = 0; m_run = 0; m_quiet = 0;
         end else if (m_words == SEARCH_TIMEOUT) begin
            m_off = (m_off + 1) % 10; m_words = 0; m_run = 0;
         end
      end else if (tc >= 0) begin
         m_ctrl = tc[1:0]; m_de = 0; m_data = '0; m_quiet = 0;
      end else begin
         m_quiet++;
         if (m_quiet == TOKEN_TIMEOUT) begin
            m_locked = 0; m_de = 0; m_data = '0; m_ctrl = '0;
            m_off = (m_off + 1) % 10; m_quiet = 0; m_words = 0; m_run = 0;
         end else begin
            m_de = 1; m_data = ref_decode(w);
         end
      end
   endtask

   task automatic push(input logic [9:0] raw);
      logic [3:0] mo;
      tmds_raw_in = raw;
      @(posedge clk_pixel_in);
      #1;
      model_step(int'(raw));
      mo = m_offout[3:0];
      check("model", {15'd0, locked_out, offset_out, de_out, data_out, ctrl_out},
            {15'd0, m_locked, mo, m_de, m_data, m_ctrl});
   endtask

   task automatic tx_init(input int phase);
      tx_bits.delete();
      repeat (phase) tx_bits.push_back(1'b0);
   endtask

   task automatic send_sym(input logic [9:0] s);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) tx_bits.push_back(s[i]);
      while (tx_bits.size() >= 10) begin
         for (int i = 0; i < 10; i++) r[i] = tx_bits.pop_front();
         push(r);
      end
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      @(posedge clk_pixel_in);
      #1;
      model_reset();
      check("reset_outputs", {15'd0, locked_out, offset_out, de_out, data_out, ctrl_out}, 32'd0);
      $display("reset: locked=%b offset=%0d de=%b data=%h ctrl=%b",
               locked_out, offset_out, de_out, data_out, ctrl_out);
      rst_in = 1'b0;
   endtask

   task automatic lock_run(input string name, input int exp_words, input int exp_off);
      int n = 0;
      while (!locked_out && n < 2000) begin
         send_sym(tok_tab[0]);
         n++;
         off_hist[n] = int'(offset_out);
      end
      check({name, "_words"}, n, exp_words);
      check({name, "_offset"}, {28'd0, offset_out}, exp_off);
      $display("%s: locked after %0d words at offset %0d", name, n, offset_out);
   endtask

   initial begin
      int kind, len;
      vecs[0] = '{tok_tab[3], 1'b0, 8'h00, 2'b11};
      vecs[1] = '{tok_tab[3], 1'b0, 8'h00, 2'b11};
      vecs[2] = '{tmds_encode(8'h00), 1'b1, 8'h00, 2'b11};
      vecs[3] = '{tmds_encode(8'hFF), 1'b1, 8'hFF, 2'b11};
      vecs[4] = '{tmds_encode(8'hA5), 1'b1, 8'hA5, 2'b11};
      vecs[5] = '{tok_tab[3], 1'b0, 8'h00, 2'b11};
      vecs[6] = '{tok_tab[0], 1'b0, 8'h00, 2'b00};
      vecs[7] = '{tok_tab[1], 1'b0, 8'h00, 2'b01};
      vecs[8] = '{tok_tab[2], 1'b0, 8'h00, 2'b10};
      vecs[9] = '{tok_tab[3], 1'b0, 8'h00, 2'b11};

      // Aligned token stream.
      do_reset();
      tx_init(0);
      lock_run("aligned_lock", LOCK_COUNT + 2, 0);
      check("aligned_ctrl", {30'd0, ctrl_out}, 0);
      check("aligned_de", {31'd0, de_out}, 0);

      // Stream delayed by 3 bits: slip through offsets 0..2.
      do_reset();
      tx_init(3);
      lock_run("slip_lock", 3 * SEARCH_TIMEOUT + LOCK_COUNT, 3);
      check("slip_off_64", off_hist[64], 0);
      check("slip_off_65", off_hist[65], 1);
      check("slip_off_128", off_hist[128], 1);
      check("slip_off_129", off_hist[129], 2);
      check("slip_off_192", off_hist[192], 2);
      check("slip_off_193", off_hist[193], 3);

      // Lock at phase 7, then data decode and token mapping table.
      do_reset();
      tx_init(7);
      lock_run("p7_lock", 7 * SEARCH_TIMEOUT + LOCK_COUNT, 7);
      for (int i = 0; i < 12; i++) begin
         send_sym((i < 10) ? vecs[i].sym : tok_tab[3]);
         if (i >= 2) begin
            check("vec_de", {31'd0, de_out}, {31'd0, vecs[i-2].exp_de});
            check("vec_data", {24'd0, data_out}, {24'd0, vecs[i-2].exp_data});
            check("vec_ctrl", {30'd0, ctrl_out}, {30'd0, vecs[i-2].exp_ctrl});
            $display("vec %0d: sym=%h de=%b data=%h ctrl=%b", i - 2, vecs[i-2].sym,
                     de_out, data_out, ctrl_out);
         end
      end

      // Loss of lock after TOKEN_TIMEOUT data words without a token.
      for (int i = 0; i <= TOKEN_TIMEOUT + 2; i++) begin
         send_sym(tmds_encode(8'($urandom)));
         if (i == TOKEN_TIMEOUT) check("still_locked", {31'd0, locked_out}, 1);
         if (i == TOKEN_TIMEOUT + 1) begin
            check("lock_lost", {31'd0, locked_out}, 0);
            check("lost_de", {31'd0, de_out}, 0);
            check("lost_data", {24'd0, data_out}, 0);
         end
         if (i == TOKEN_TIMEOUT + 2) check("lost_offset", {28'd0, offset_out}, 8);
      end
      $display("loss: locked=%b offset=%0d", locked_out, offset_out);

      // Reset in the middle of a lock at offset 5, then re-lock.
      do_reset();
      tx_init(5);
      lock_run("p5_lock", 5 * SEARCH_TIMEOUT + LOCK_COUNT, 5);
      repeat (3) send_sym(tok_tab[0]);
      do_reset();
      lock_run("p5_relock", 5 * SEARCH_TIMEOUT + LOCK_COUNT, 5);

      // Random traffic in bursts at a random phase, checked by the model each word.
      do_reset();
      tx_init($urandom_range(0, 9));
      for (int b = 0; b < 400; b++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 20);
         for (int k = 0; k < len; k++) begin
            if (kind == 0)      push(10'($urandom));
            else if (kind < 6)  send_sym(tok_tab[$urandom_range(0, 3)]);
            else                send_sym(tmds_encode(8'($urandom)));
         end
      end
      $display("random: final locked=%b offset=%0d", locked_out, offset_out);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
